// File: rtl/interrupter_mc_pkg.sv
// Shared constants for the multi-channel interrupt controller and its bus window.
package interrupter_mc_pkg;

    // Privilege mode encodings used by the core.
    localparam logic [1:0] M_MODE = 2'b11;
    localparam logic [1:0] S_MODE = 2'b01;
    localparam logic [1:0] U_MODE = 2'b00;

    // Register word offsets inside the controller window (address bits [3:2]).
    localparam logic [1:0] INTC_ENABLE = 2'd0;
    localparam logic [1:0] INTC_MODE   = 2'd1;
    localparam logic [1:0] INTC_PEND   = 2'd2;
    localparam logic [1:0] INTC_CLAIM  = 2'd3;

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module intr_prio_enc #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req,
    output logic [IDW-1:0] id,
    output logic           any
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        id  = '0;
        any = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) id = IDW'(i);
        end
    end

endmodule

// File: rtl/interrupter_mc.sv
// Multi-channel interrupt controller: sync, edge/level pending, mask,
// fixed priority select, claim/complete handshake over a small register window.
module interrupter_mc
    import interrupter_mc_pkg::*;
#(
    parameter int NIRQ        = 8,
    parameter int IDW         = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            csr_meie,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_wadr,
    input  logic [31:0]     cfg_wdata,
    input  logic            cfg_re,
    input  logic [1:0]      cfg_radr,
    output logic [31:0]     cfg_rdata,
    output logic            g_interrupt,
    output logic            irq_busy,
    output logic [IDW-1:0]  irq_id
);

    logic [SYNC_STAGES-1:0][NIRQ-1:0] sync_q, sync_d;
    logic [NIRQ-1:0] s_dly_q, s_dly_d;
    logic [NIRQ-1:0] enable_q, enable_d;
    logic [NIRQ-1:0] mode_q, mode_d;
    logic [NIRQ-1:0] pend_q, pend_d;
    logic            busy_q, busy_d;
    logic [IDW-1:0]  svc_id_q, svc_id_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            gint_q, gint_d;

    logic [NIRQ-1:0] s_irq, rise, cand, w1c, claim_clr, mode_flush;
    logic [IDW-1:0]  cand_id;
    logic            cand_any, cmpl_hit, busy_mid, claim_rd, claim_ok;
    logic [NIRQ-1:0] wdata_n;
    logic            unused_wdata;

    assign wdata_n      = cfg_wdata[NIRQ-1:0];
    assign unused_wdata = &{1'b0, cfg_wdata};

    assign s_irq = sync_q[SYNC_STAGES-1];
    assign rise  = s_irq & ~s_dly_q;
    assign cand  = pend_q & enable_q;

    intr_prio_enc #(.N(NIRQ), .IDW(IDW)) u_enc (
        .req (cand),
        .id  (cand_id),
        .any (cand_any)
    );

    // Claim/complete decode; a complete in the same cycle is applied before the claim.
    always_comb begin
        cmpl_hit  = cfg_we && (cfg_wadr == INTC_CLAIM) && busy_q &&
                    (cfg_wdata[IDW:0] == ((IDW+1)'(svc_id_q) + (IDW+1)'(1)));
        busy_mid  = busy_q && !cmpl_hit;
        claim_rd  = cfg_re && (cfg_radr == INTC_CLAIM);
        claim_ok  = claim_rd && cand_any && !busy_mid;
        claim_clr = claim_ok ? (NIRQ'(1) << cand_id) : '0;
        w1c       = (cfg_we && (cfg_wadr == INTC_PEND)) ? wdata_n : '0;
        mode_flush = (cfg_we && (cfg_wadr == INTC_MODE)) ? (mode_q ^ wdata_n) : '0;
    end

    // Next-state for sync chain, config registers, pending and service state.
    always_comb begin
        sync_d[0] = irq_in;
        for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
        s_dly_d  = s_irq;
        enable_d = (cfg_we && (cfg_wadr == INTC_ENABLE)) ? wdata_n : enable_q;
        mode_d   = (cfg_we && (cfg_wadr == INTC_MODE))   ? wdata_n : mode_q;

        // Edge channels: set beats clear. Level channels follow the synced line.
        pend_d = (mode_q & (((pend_q & ~(w1c | claim_clr))) | rise)) |
                 (~mode_q & s_irq);
        pend_d = pend_d & ~mode_flush;

        busy_d   = claim_ok ? 1'b1 : busy_mid;
        svc_id_d = claim_ok ? cand_id : svc_id_q;

        rdata_d = rdata_q;
        if (cfg_re) begin
            case (cfg_radr)
                INTC_ENABLE: rdata_d = 32'(enable_q);
                INTC_MODE:   rdata_d = 32'(mode_q);
                INTC_PEND:   rdata_d = 32'(pend_q);
                default:     rdata_d = claim_ok ? 32'(cand_id) + 32'd1 : 32'd0;
            endcase
        end

        gint_d = csr_meie && cand_any && !busy_q;
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            s_dly_q  <= '0;
            enable_q <= '0;
            mode_q   <= '0;
            pend_q   <= '0;
            busy_q   <= 1'b0;
            svc_id_q <= '0;
            rdata_q  <= '0;
            gint_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            s_dly_q  <= s_dly_d;
            enable_q <= enable_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            busy_q   <= busy_d;
            svc_id_q <= svc_id_d;
            rdata_q  <= rdata_d;
            gint_q   <= gint_d;
        end
    end

    assign cfg_rdata   = rdata_q;
    assign g_interrupt = gint_q;
    assign irq_busy    = busy_q;
    assign irq_id      = cand_id;

endmodule

// File: tb/tb_interrupter_mc.sv
// Self-checking bench for interrupter_mc: directed corner cases, a register
// vector table and a randomized run against a rule-level reference model.
module tb_interrupter_mc;

    localparam int NIRQ = 8;
    localparam int IDW  = 3;
    localparam int SYNC = 2;

    logic            clk, rst_n;
    logic [NIRQ-1:0] irq_in;
    logic            csr_meie, cfg_we, cfg_re;
    logic [1:0]      cfg_wadr, cfg_radr;
    logic [31:0]     cfg_wdata, cfg_rdata;
    logic            g_interrupt, irq_busy;
    logic [IDW-1:0]  irq_id;

    int total = 0;
    int bad   = 0;

    interrupter_mc #(.NIRQ(NIRQ), .IDW(IDW), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .csr_meie(csr_meie),
        .cfg_we(cfg_we), .cfg_wadr(cfg_wadr), .cfg_wdata(cfg_wdata),
        .cfg_re(cfg_re), .cfg_radr(cfg_radr), .cfg_rdata(cfg_rdata),
        .g_interrupt(g_interrupt), .irq_busy(irq_busy), .irq_id(irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [NIRQ-1:0] m_pend, m_en, m_mode;
    logic            m_busy, m_gint;
    logic [IDW-1:0]  m_svc;
    logic [31:0]     m_rd;
    logic [NIRQ-1:0] hist [0:SYNC];   // hist[k]: line value sampled k+1 edges ago

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [NIRQ-1:0] v);
        for (int i = 0; i < NIRQ; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_en = '0; m_mode = '0; m_busy = 0; m_gint = 0; m_svc = '0; m_rd = '0;
        for (int k = 0; k <= SYNC; k++) hist[k] = '0;
    endtask

    // One clock: advance model from the driven inputs, then compare after the edge.
    task automatic tick();
        logic [NIRQ-1:0] cand, s, sd, np, cl;
        logic nb, any;
        int id;
        cand = m_pend & m_en;
        any  = (cand != 0);
        id   = lowest(cand);
        s    = hist[SYNC-1];
        sd   = hist[SYNC];
        nb   = m_busy;
        cl   = '0;
        if (cfg_we && cfg_wadr == 2'd3 && m_busy && cfg_wdata[IDW:0] == 4'(m_svc) + 4'd1) nb = 0;
        if (cfg_re) begin
            case (cfg_radr)
                2'd0: m_rd = 32'(m_en);
                2'd1: m_rd = 32'(m_mode);
                2'd2: m_rd = 32'(m_pend);
                default: begin
                    if (any && !nb) begin
                        m_rd = id + 1; nb = 1; m_svc = IDW'(id);
                        if (m_mode[id]) cl[id] = 1'b1;
                    end else m_rd = 0;
                end
            endcase
        end
        if (cfg_we && cfg_wadr == 2'd2) cl = cl | cfg_wdata[NIRQ-1:0];
        for (int i = 0; i < NIRQ; i++) begin
            if (!m_mode[i]) np[i] = s[i];
            else if (s[i] && !sd[i]) np[i] = 1'b1;
            else np[i] = m_pend[i] & ~cl[i];
            if (cfg_we && cfg_wadr == 2'd1 && cfg_wdata[i] != m_mode[i]) np[i] = 1'b0;
        end
        m_gint = csr_meie && any && !m_busy;
        if (cfg_we && cfg_wadr == 2'd0) m_en   = cfg_wdata[NIRQ-1:0];
        if (cfg_we && cfg_wadr == 2'd1) m_mode = cfg_wdata[NIRQ-1:0];
        m_pend = np;
        m_busy = nb;
        for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = irq_in;
        @(posedge clk);
        #1;
        cfg_we = 0;
        cfg_re = 0;
        check("model_gint", 32'(g_interrupt), 32'(m_gint));
        check("model_busy", 32'(irq_busy), 32'(m_busy));
        check("model_rdata", cfg_rdata, m_rd);
        if ((m_pend & m_en) != 0) check("model_id", 32'(irq_id), 32'(lowest(m_pend & m_en)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1; cfg_wadr = a; cfg_wdata = d;
        tick();
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        cfg_re = 1; cfg_radr = a;
        tick();
        d = cfg_rdata;
    endtask

    // Reset applied between clock edges; outputs must clear without waiting for an edge.
    task automatic do_reset();
        rst_n = 0;
        model_reset();
        #1;
        check("rst_busy", 32'(irq_busy), 0);
        check("rst_gint", 32'(g_interrupt), 0);
        check("rst_rdata", cfg_rdata, 0);
        #2;
        rst_n = 1;
    endtask

    typedef struct {
        logic [1:0]  wadr;
        logic [31:0] wdata;
        logic [1:0]  radr;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t vt [6];
        logic [31:0] r;
        rst_n = 1; irq_in = '0; csr_meie = 1; cfg_we = 0; cfg_re = 0;
        cfg_wadr = 0; cfg_radr = 0; cfg_wdata = 0;
        #1;
        do_reset();

        // Register write/readback table (upper bits must be dropped)
        vt[0] = '{2'd0, 32'hFFFF_FFA5, 2'd0, 32'h0000_00A5};
        vt[1] = '{2'd1, 32'h1234_5600, 2'd1, 32'h0000_0000};
        vt[2] = '{2'd1, 32'hFFFF_FF0F, 2'd1, 32'h0000_000F};
        vt[3] = '{2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000};
        vt[4] = '{2'd2, 32'h0000_00FF, 2'd2, 32'h0000_0000};
        vt[5] = '{2'd0, 32'h0000_0003, 2'd3, 32'h0000_0000};
        for (int i = 0; i < 6; i++) begin
            wr(vt[i].wadr, vt[i].wdata);
            rd(vt[i].radr, r);
            check($sformatf("vec%0d", i), r, vt[i].exp);
        end

        // 1: edge pulse latency and claim
        do_reset();
        wr(0, 32'h01); wr(1, 32'h01);
        irq_in[0] = 1;
        for (int k = 1; k <= SYNC + 2; k++) begin
            tick();
            irq_in[0] = 0;
            check($sformatf("t1_lat%0d", k), 32'(g_interrupt), 32'(k == SYNC + 2));
        end
        rd(3, r);
        check("t1_claim", r, 1);
        check("t1_busy", 32'(irq_busy), 1);
        tick();
        check("t1_gint_off", 32'(g_interrupt), 0);

        // 2: two simultaneous edges serviced lowest first
        do_reset();
        wr(0, 32'hFF); wr(1, 32'hFF);
        irq_in = 8'h24;
        idle(SYNC + 2);
        rd(3, r); check("t2_claim_a", r, 3);
        wr(3, 3);
        rd(3, r); check("t2_claim_b", r, 6);
        wr(3, 6);
        rd(3, r); check("t2_claim_c", r, 0);
        irq_in = '0;

        // 3: level channel re-asserts after complete, clears after line drops
        do_reset();
        wr(0, 32'h02);
        irq_in[1] = 1;
        idle(SYNC + 2);
        rd(3, r); check("t3_claim", r, 2);
        wr(3, 2);
        check("t3_gint_c0", 32'(g_interrupt), 0);
        check("t3_busy", 32'(irq_busy), 0);
        tick();
        check("t3_gint_c1", 32'(g_interrupt), 1);
        irq_in[1] = 0;
        idle(SYNC + 1);
        check("t3_gint_hold", 32'(g_interrupt), 1);
        tick();
        check("t3_gint_drop", 32'(g_interrupt), 0);

        // 4: new edge wins over W1C in the same cycle; wrong-id complete ignored
        do_reset();
        wr(0, 32'h10); wr(1, 32'h10);
        irq_in[4] = 1; tick(); irq_in[4] = 0;
        idle(SYNC + 2);
        irq_in[4] = 1;
        idle(SYNC);
        wr(2, 32'h10);
        rd(2, r); check("t4_pend", r, 32'h10);
        rd(3, r); check("t4_claim", r, 5);
        wr(3, 7);
        check("t4_busy", 32'(irq_busy), 1);
        irq_in[4] = 0;

        // 5: meie gates the request but not the claim; reset mid-service
        do_reset();
        csr_meie = 0;
        wr(0, 32'h01); wr(1, 32'h01);
        irq_in[0] = 1; tick(); irq_in[0] = 0;
        for (int k = 0; k < SYNC + 2; k++) begin
            tick();
            check("t5_gint", 32'(g_interrupt), 0);
        end
        rd(3, r); check("t5_claim", r, 1);
        check("t5_busy", 32'(irq_busy), 1);
        do_reset();
        rd(2, r); check("t5_pend", r, 0);
        csr_meie = 1;

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) irq_in[$urandom_range(NIRQ-1)] ^= 1'b1;
            if ($urandom_range(63) == 0) csr_meie = ~csr_meie;
            if ($urandom_range(3) == 0) begin
                cfg_we = 1;
                cfg_wadr = 2'($urandom_range(3));
                cfg_wdata = (cfg_wadr == 2'd3) ? 32'($urandom_range(9)) : $urandom;
                if (cfg_wadr == 2'd1 && $urandom_range(3) != 0) cfg_wdata = 32'(m_mode);
            end
            if ($urandom_range(2) == 0) begin
                cfg_re = 1;
                cfg_radr = 2'($urandom_range(3));
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
